// File: rtl/seq_mem_ctrl_pkg.sv
// Purpose: shared defaults, FSM state encoding and command arbitration for
//          the game-sequence RAM controller.
// Contents: SMC_* size defaults, state_e, cmd_e, cmd_select().
package seq_mem_ctrl_pkg;

  localparam int unsigned SMC_DEPTH = 16;  // RAM entries / max sequence length
  localparam int unsigned SMC_AW    = 4;   // RAM address width
  localparam int unsigned SMC_DW    = 4;   // width of one move
  localparam int unsigned SMC_GAP   = 4;   // hold cycles per played item

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLR       = 4'd1,
    ST_APP       = 4'd2,
    ST_PLAY_RD   = 4'd3,
    ST_PLAY_CAP  = 4'd4,
    ST_PLAY_HOLD = 4'd5,
    ST_CHK_RD    = 4'd6,
    ST_CHK_CMP   = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  // Ordered by priority: the earliest non-NONE entry wins.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_CLEAR  = 3'd1,
    CMD_APPEND = 3'd2,
    CMD_PLAY   = 3'd3,
    CMD_CHECK  = 3'd4
  } cmd_e;

  // Resolve simultaneous command pulses: clear > append > play > check.
  function automatic cmd_e cmd_select(input logic clr, input logic app,
                                      input logic ply, input logic chk);
    cmd_e sel;
    sel = CMD_NONE;
    if (clr)      sel = CMD_CLEAR;
    else if (app) sel = CMD_APPEND;
    else if (ply) sel = CMD_PLAY;
    else if (chk) sel = CMD_CHECK;
    return sel;
  endfunction

endpackage

// File: rtl/seq_mem_ctrl_hold_timer.sv
// Purpose: GAP-cycle down-counter that times how long a played-back item is
//          presented.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   i_load        reload the counter so that expiry happens GAP cycles later
//   o_expire_c    combinational: high in the last cycle of the hold window
module seq_mem_ctrl_hold_timer
  import seq_mem_ctrl_pkg::*;
#(
  parameter int unsigned GAP = SMC_GAP
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_expire_c
);

  localparam int unsigned TW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [TW-1:0] r_cnt;

  // Load with GAP-1 so that the counts GAP-1..0 span exactly GAP cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TW'(GAP - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire_c = (r_cnt == '0);

endmodule

// File: rtl/seq_mem_ctrl.sv
// Purpose: owner of the single port of the game-sequence RAM. Executes clear,
//          append, play-back and check commands from the game FSM, tracks the
//          sequence length and check pointer, and absorbs the one-cycle RAM
//          read latency.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   cmd_clear/append/play/check          start pulses, taken only when idle
//   din                                  move for append/check
//   busy, done                           command in progress / end pulse
//   err_full                             append refused, sequence full
//   len                                  current sequence length 0..DEPTH
//   play_valid/play_data/play_last       play-back stream
//   chk_match/chk_mismatch/chk_last      check result pulses
//   ram_we/ram_addr/ram_din/ram_q        RAM port (q valid one cycle after addr)
module seq_mem_ctrl
  import seq_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SMC_DEPTH,
  parameter int unsigned AW    = SMC_AW,
  parameter int unsigned DW    = SMC_DW,
  parameter int unsigned GAP   = SMC_GAP
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_clear,
  input  logic          cmd_append,
  input  logic          cmd_play,
  input  logic          cmd_check,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          err_full,
  output logic [AW:0]   len,
  output logic          play_valid,
  output logic [DW-1:0] play_data,
  output logic          play_last,
  output logic          chk_match,
  output logic          chk_mismatch,
  output logic          chk_last,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_q
);

  localparam int unsigned LW = AW + 1;

  state_e        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_err_full;
  logic [LW-1:0] r_len;
  logic          r_play_valid;
  logic [DW-1:0] r_play_data;
  logic          r_play_last;
  logic          r_chk_match;
  logic          r_chk_mismatch;
  logic          r_chk_last;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic [DW-1:0] r_din_q;
  logic [AW-1:0] r_chk_ptr;
  logic [AW-1:0] r_idx;

  cmd_e          w_cmd;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_len_m1;
  logic          w_timer_load;
  logic          w_timer_expire;

  assign w_cmd        = cmd_select(cmd_clear, cmd_append, cmd_play, cmd_check);
  assign w_full       = (r_len == LW'(DEPTH));
  assign w_empty      = (r_len == '0);
  assign w_len_m1     = r_len - LW'(1);
  assign w_timer_load = (r_state == ST_PLAY_CAP);

  // Hold window for each played item starts on the cycle after capture.
  seq_mem_ctrl_hold_timer #(
    .GAP(GAP)
  ) u_hold_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_timer_load),
    .o_expire_c(w_timer_expire)
  );

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_full     <= 1'b0;
      r_len          <= '0;
      r_play_valid   <= 1'b0;
      r_play_data    <= '0;
      r_play_last    <= 1'b0;
      r_chk_match    <= 1'b0;
      r_chk_mismatch <= 1'b0;
      r_chk_last     <= 1'b0;
      r_ram_we       <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_din      <= '0;
      r_din_q        <= '0;
      r_chk_ptr      <= '0;
      r_idx          <= '0;
    end else begin
      // Result flags are single-cycle pulses; they are raised only on the
      // edge that enters DONE.
      r_done         <= 1'b0;
      r_err_full     <= 1'b0;
      r_chk_match    <= 1'b0;
      r_chk_mismatch <= 1'b0;
      r_chk_last     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_cmd != CMD_NONE) begin
            r_din_q <= din;
          end
          case (w_cmd)
            CMD_CLEAR: begin
              r_busy     <= 1'b1;
              r_state    <= ST_CLR;
              r_ram_we   <= 1'b1;
              r_ram_addr <= '0;
              r_ram_din  <= '0;
            end
            CMD_APPEND: begin
              r_busy  <= 1'b1;
              r_state <= ST_APP;
              // A full sequence still spends the APP cycle, just without a write.
              if (!w_full) begin
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_len[AW-1:0];
                r_ram_din  <= din;
              end
            end
            CMD_PLAY: begin
              if (w_empty) begin
                r_done    <= 1'b1;
                r_chk_ptr <= '0;
                r_state   <= ST_DONE;
              end else begin
                r_busy     <= 1'b1;
                r_state    <= ST_PLAY_RD;
                r_idx      <= '0;
                r_ram_addr <= '0;
              end
            end
            CMD_CHECK: begin
              if (w_empty) begin
                r_done         <= 1'b1;
                r_chk_mismatch <= 1'b1;
                r_chk_ptr      <= '0;
                r_state        <= ST_DONE;
              end else begin
                r_busy     <= 1'b1;
                r_state    <= ST_CHK_RD;
                r_ram_addr <= r_chk_ptr;
              end
            end
            default: ;
          endcase
        end

        // Sweep every address writing zero; the address register is the counter.
        ST_CLR: begin
          if (r_ram_addr == AW'(DEPTH - 1)) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_len      <= '0;
            r_chk_ptr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_ram_addr <= r_ram_addr + 1'b1;
          end
        end

        ST_APP: begin
          r_ram_we   <= 1'b0;
          r_ram_addr <= '0;
          r_ram_din  <= '0;
          if (w_full) begin
            r_err_full <= 1'b1;
          end else begin
            r_len <= r_len + 1'b1;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        // Address is presented this cycle; the RAM samples it at the edge.
        ST_PLAY_RD: begin
          r_state <= ST_PLAY_CAP;
        end

        ST_PLAY_CAP: begin
          r_play_data  <= ram_q;
          r_play_valid <= 1'b1;
          r_play_last  <= ({1'b0, r_idx} == w_len_m1);
          r_state      <= ST_PLAY_HOLD;
        end

        ST_PLAY_HOLD: begin
          if (w_timer_expire) begin
            r_play_valid <= 1'b0;
            r_play_last  <= 1'b0;
            if (r_play_last) begin
              r_ram_addr <= '0;
              r_chk_ptr  <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_ram_addr <= r_idx + 1'b1;
              r_state    <= ST_PLAY_RD;
            end
          end
        end

        ST_CHK_RD: begin
          r_state <= ST_CHK_CMP;
        end

        // Matching the final stored move wraps the pointer for the next round.
        ST_CHK_CMP: begin
          r_ram_addr <= '0;
          if (ram_q == r_din_q) begin
            r_chk_match <= 1'b1;
            if ({1'b0, r_chk_ptr} == w_len_m1) begin
              r_chk_last <= 1'b1;
              r_chk_ptr  <= '0;
            end else begin
              r_chk_ptr <= r_chk_ptr + 1'b1;
            end
          end else begin
            r_chk_mismatch <= 1'b1;
            r_chk_ptr      <= '0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err_full     = r_err_full;
  assign len          = r_len;
  assign play_valid   = r_play_valid;
  assign play_data    = r_play_data;
  assign play_last    = r_play_last;
  assign chk_match    = r_chk_match;
  assign chk_mismatch = r_chk_mismatch;
  assign chk_last     = r_chk_last;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;

endmodule

// File: doc/seq_mem_ctrl.md
Name: seq_mem_ctrl

Overview:
- Controller that owns the single port of the 16x4 synchronous game-sequence RAM.
- The game FSM issues commands to it: clear memory, append a move, play back the stored sequence, or check a player move against the stored move at the current check position.
- Tracks the sequence length and check pointer, serialises RAM accesses, and accounts for the RAM's registered-address read latency (q valid one cycle after the address is sampled).

Parameters:
DEPTH, 16, number of RAM entries (max sequence length)
AW, 4, RAM address width (log2 DEPTH)
DW, 4, data width of one move
GAP, 4, cycles each played-back item is held with play_valid high (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_clear  in  1  start pulse: write 0 to all entries, len=0
cmd_append  in  1  start pulse: write din at address len
cmd_play  in  1  start pulse: stream entries 0..len-1
cmd_check  in  1  start pulse: compare din with entry chk_ptr
din  in  DW  move data for append/check, sampled on accepted command cycle
busy  out  1  high while a command executes
done  out  1  one-cycle pulse at end of every accepted command
err_full  out  1  one-cycle pulse with done when append is refused (len==DEPTH)
len  out  AW+1  current sequence length 0..DEPTH
play_valid  out  1  high while play_data holds a valid item
play_data  out  DW  item being played back
play_last  out  1  high with play_valid for the final item
chk_match  out  1  one-cycle pulse with done: din equalled stored move
chk_mismatch  out  1  one-cycle pulse with done: din differed, or len==0
chk_last  out  1  pulse with chk_match when the matched move was entry len-1
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_q  in  DW  RAM read data (valid the cycle after ram_addr is sampled)

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; len=0; chk_ptr=0; play_data=0. RAM contents are not touched. Reset mid-command aborts immediately; partially cleared or written RAM contents remain.
- Commands are accepted only in IDLE (busy=0). Commands asserted while busy are ignored.
- Simultaneous commands resolve by priority: clear > append > play > check.
- On acceptance, din is latched into din_q; busy rises on the next cycle.
- States: IDLE, CLR, APP, PLAY_RD, PLAY_CAP, PLAY_HOLD, CHK_RD, CHK_CMP, DONE.
- CLR:
  - DEPTH cycles with ram_we=1, ram_din=0, ram_addr=0..DEPTH-1.
  - Then DONE; len=0, chk_ptr=0.
  - Total latency: DEPTH+1 cycles to the done pulse.
- APP:
  - If len<DEPTH: one cycle with ram_we=1, ram_addr=len[AW-1:0], ram_din=din_q; len increments at the end of that cycle.
  - If len==DEPTH: no write, err_full pulses with done.
  - done pulses 2 cycles after acceptance.
- PLAY:
  - If len==0: go straight to DONE, play_valid never rises.
  - Otherwise, per index i=0..len-1:
    - PLAY_RD: ram_addr=i, 1 cycle.
    - PLAY_CAP: ram_q captured into play_data, 1 cycle.
    - PLAY_HOLD: GAP cycles, play_valid=1, play_last=(i==len-1).
  - Items are spaced GAP+2 cycles apart; play_valid is low during RD/CAP.
  - After the last item, go to DONE; chk_ptr is reset to 0.
- CHECK:
  - If len==0: go to DONE with chk_mismatch.
  - Otherwise:
    - CHK_RD: ram_addr=chk_ptr.
    - CHK_CMP: compare ram_q with din_q.
    - DONE: the result pulse is issued.
  - Match: chk_ptr increments. If chk_ptr was len-1, chk_last pulses and chk_ptr wraps to 0.
  - Mismatch: chk_ptr is reset to 0.
  - done pulses 3 cycles after acceptance.
- DONE: one cycle, done=1, busy=0 in this cycle, then IDLE. A new command may be accepted in the cycle after DONE.
- ram_we is 0 in every state except CLR and a non-full APP. ram_addr is held at 0 in IDLE.
- len never exceeds DEPTH. len changes only via CLR and APP, never via reset of chk_ptr.

Decomposition:
- Shared include/package: state encodings (localparams), DEPTH/AW/DW defaults, command priority constants.
- One natural sub-module, hold_timer: a GAP-cycle down-counter with load/expire, used by PLAY_HOLD.
- The RAM instance stays outside this block; the controller only drives its port.

Test Plan:
- Reset, then clear -> ram_we high for 16 consecutive cycles, addr 0..15, din 0; done 17 cycles after accept; len=0.
- Append 3,7,1 -> len=3; then play -> play_data 3,7,1 each valid 4 cycles, 2 idle cycles between items, play_last only with 1, done after the last item.
- After the above: check 3, check 7, check 1 -> match, match, match+chk_last; chk_ptr back to 0; check 3 again -> match.
- Check 3 then check 5 -> match then mismatch; next check 3 -> match (pointer was reset to 0).
- 16 appends then a 17th -> err_full with done, no ram_we, len stays 16.
- cmd_append and cmd_play in the same cycle -> append runs; cmd_check during play ignored; reset_n low mid-play -> all outputs 0 immediately, len=0.
